ft245_iq_unpacker: RTL

- Downstream consumer of the FT245 block's receive simple interface (rx_data_si / rx_valid_si / rx_ready_si).
- Assembles the host byte stream into 16-bit signed I/Q sample pairs and buffers them in a synchronous FIFO.
- Releases one pair per sample_req strobe from the modulator/DAC path.
- Substitutes zero samples and counts underruns when the buffer runs dry.

---
 rtl/ft245_pkg.sv | 33 +++
 rtl/ft245_sync_fifo.sv | 90 +++++++++
 rtl/ft245_iq_unpacker.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ft245_pkg.sv
// ---------------------------------------------------------------------------
// ft245_pkg
// Shared constants and types for the FT245 receive-side I/Q unpacker.
//   IQ_BYTES        : host bytes that make up one {I,Q} sample pair
//   SAMPLE_W        : width of one signed I or Q sample
//   IQ_W            : width of one buffered {I,Q} word
//   FIFO_AW_DEFAULT : default sample FIFO address width
//   UNDERRUN_SAT    : value at which the underrun counter stops counting
//   bytePhase_e     : position of the next host byte within a sample pair
// ---------------------------------------------------------------------------
package ft245_pkg;

    localparam int          IQ_BYTES        = 4;
    localparam int          SAMPLE_W        = 16;
    localparam int          IQ_W            = 2 * SAMPLE_W;
    localparam int          FIFO_AW_DEFAULT = 6;
    localparam logic [15:0] UNDERRUN_SAT    = 16'hFFFF;

    // Host stream is little-endian, I first: I low, I high, Q low, Q high.
    typedef enum logic [$clog2(IQ_BYTES)-1:0] {
        PH_I_LO = 2'd0,
        PH_I_HI = 2'd1,
        PH_Q_LO = 2'd2,
        PH_Q_HI = 2'd3
    } bytePhase_e;

    // Buffered word layout: I in the upper half, Q in the lower half.
    function automatic logic [IQ_W-1:0] packIq(input logic [SAMPLE_W-1:0] iSample,
                                               input logic [SAMPLE_W-1:0] qSample);
        return {iSample, qSample};
    endfunction

endpackage

// File: rtl/ft245_sync_fifo.sv
// ---------------------------------------------------------------------------
// ft245_sync_fifo
// Single-clock FIFO with a registered read port and synchronous flush.
// A read request always updates the read register: with the head word when
// the FIFO holds data, with zero when it is empty or being flushed. That
// lets the consumer use the read register directly as its sample output.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush_i          : clears pointers and level this cycle (wins over writes)
//   wr_en_i/wr_data_i: push request and data (ignored while full)
//   rd_en_i          : pop request
//   rd_data_o        : registered read data
//   full_o, empty_o  : status from the registered level
//   level_o          : words currently stored (AW+1 bits)
// ---------------------------------------------------------------------------
module ft245_sync_fifo #(
    parameter int W  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   level_q, level_d;
    logic [W-1:0]  rdData_q, rdData_d;
    logic          wrFire;
    logic          rdFire;

    assign full_o    = (level_q == DEPTH_LVL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = rdData_q;

    assign wrFire = wr_en_i && !full_o && !flush_i;
    assign rdFire = rd_en_i && !empty_o && !flush_i;

    // Pointer, level and read-register next state. A simultaneous push and
    // pop leaves the level unchanged; a write into an empty FIFO is not
    // bypassed to the read port.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        level_d  = level_q;
        rdData_d = rdData_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (wrFire) wrPtr_d = wrPtr_q + AW'(1);
            if (rdFire) rdPtr_d = rdPtr_q + AW'(1);
            level_d = level_q + (AW+1)'(wrFire) - (AW+1)'(rdFire);
        end
        if (rd_en_i) rdData_d = rdFire ? mem_q[rdPtr_q] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            level_q  <= '0;
            rdData_q <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            level_q  <= level_d;
            rdData_q <= rdData_d;
        end
    end

    // Storage has no reset; only words below the level are ever read.
    always_ff @(posedge clk) begin
        if (wrFire) mem_q[wrPtr_q] <= wr_data_i;
    end

endmodule

// File: rtl/ft245_iq_unpacker.sv
// ---------------------------------------------------------------------------
// ft245_iq_unpacker
// Turns the FT245 receive byte stream into 16-bit signed I/Q pairs, buffers
// them, and releases one pair per sample_req. An empty buffer yields a zero
// sample and is counted as an underrun.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   enable                : stream enable; low flushes buffer and byte phase
//   rx_data_si/valid/ready: byte stream from the FT245 block
//   sample_req            : one-cycle strobe at the sample rate
//   i_out, q_out          : registered signed samples, held between strobes
//   iq_valid              : one-cycle pulse the cycle after each strobe
//   fifo_level            : words currently buffered
//   underrun_cnt          : saturating underrun count
//   underrun              : sticky underrun flag, cleared on enable rising
// ---------------------------------------------------------------------------
module ft245_iq_unpacker
    import ft245_pkg::*;
#(
    parameter int FIFO_AW = FIFO_AW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [7:0]                 rx_data_si,
    input  logic                       rx_valid_si,
    output logic                       rx_ready_si,
    input  logic                       sample_req,
    output logic signed [SAMPLE_W-1:0] i_out,
    output logic signed [SAMPLE_W-1:0] q_out,
    output logic                       iq_valid,
    output logic [FIFO_AW:0]           fifo_level,
    output logic [15:0]                underrun_cnt,
    output logic                       underrun
);

    bytePhase_e          phase_q, phase_d;
    logic [SAMPLE_W-1:0] holdI_q, holdI_d;
    logic [7:0]          holdQLo_q, holdQLo_d;
    logic                enable_q;
    logic                iqValid_q;
    logic [15:0]         underrunCnt_q, underrunCnt_d;
    logic                underrun_q, underrun_d;

    logic                byteAccept;
    logic                fifoWrEn;
    logic [IQ_W-1:0]     fifoWrData;
    logic [IQ_W-1:0]     fifoRdData;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                underrunHit;
    logic                enableRise;

    // Ready depends only on registered FIFO state, the enable input and the
    // reset pin, so it is low throughout reset and never follows rx_valid_si.
    assign rx_ready_si = rst && enable && !fifoFull;
    assign byteAccept  = rx_valid_si && rx_ready_si;

    // The final byte completes the pair and is written straight to the FIFO
    // at the accepting edge; the upstream block holds it while we are full.
    assign fifoWrEn   = byteAccept && (phase_q == PH_Q_HI);
    assign fifoWrData = packIq(holdI_q, {rx_data_si, holdQLo_q});

    assign underrunHit = sample_req && enable && fifoEmpty;
    assign enableRise  = enable && !enable_q;

    ft245_sync_fifo #(
        .W  (IQ_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .flush_i   (!enable),
        .wr_en_i   (fifoWrEn),
        .wr_data_i (fifoWrData),
        .rd_en_i   (sample_req),
        .rd_data_o (fifoRdData),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .level_o   (fifo_level)
    );

    // Byte assembler: capture the first three bytes of each pair and step
    // the phase on every accepted byte. Dropping enable discards a partial
    // pair so the next pair starts cleanly at I low.
    always_comb begin
        phase_d   = phase_q;
        holdI_d   = holdI_q;
        holdQLo_d = holdQLo_q;
        if (!enable) begin
            phase_d = PH_I_LO;
        end else if (byteAccept) begin
            case (phase_q)
                PH_I_LO: begin
                    holdI_d[7:0] = rx_data_si;
                    phase_d      = PH_I_HI;
                end
                PH_I_HI: begin
                    holdI_d[15:8] = rx_data_si;
                    phase_d       = PH_Q_LO;
                end
                PH_Q_LO: begin
                    holdQLo_d = rx_data_si;
                    phase_d   = PH_Q_HI;
                end
                default: phase_d = PH_I_LO;
            endcase
        end
    end

    // Underrun tracking. A new underrun in the same cycle as the enable
    // rising edge keeps the flag set so it is never silently lost.
    always_comb begin
        underrunCnt_d = underrunCnt_q;
        underrun_d    = underrun_q;
        if (enableRise) underrun_d = 1'b0;
        if (underrunHit) begin
            underrun_d = 1'b1;
            if (underrunCnt_q != UNDERRUN_SAT) underrunCnt_d = underrunCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q       <= PH_I_LO;
            holdI_q       <= '0;
            holdQLo_q     <= '0;
            enable_q      <= 1'b0;
            iqValid_q     <= 1'b0;
            underrunCnt_q <= '0;
            underrun_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            holdI_q       <= holdI_d;
            holdQLo_q     <= holdQLo_d;
            enable_q      <= enable;
            iqValid_q     <= sample_req;
            underrunCnt_q <= underrunCnt_d;
            underrun_q    <= underrun_d;
        end
    end

    // The FIFO read register already carries either the popped word or the
    // zero substitute, and holds its value between strobes.
    assign i_out        = fifoRdData[IQ_W-1:SAMPLE_W];
    assign q_out        = fifoRdData[SAMPLE_W-1:0];
    assign iq_valid     = iqValid_q;
    assign underrun_cnt = underrunCnt_q;
    assign underrun     = underrun_q;

endmodule
